// File: rtl/cordic_pkg.sv
// Shared types and constants for the iterative CORDIC controller.
package cordic_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ITER = 2'd2,
        DONE = 2'd3
    } state_e;

    typedef enum logic {
        ROTATION  = 1'b0,
        VECTORING = 1'b1
    } mode_e;

    localparam int MaxIterations = 64;

endpackage

// File: rtl/cordic_iter_cnt.sv
// Micro-rotation index counter with clear, enable and terminal count.
module cordic_iter_cnt #(
    parameter int Iterations = 16,
    parameter int Width      = $clog2(Iterations)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    output logic [Width-1:0] count,
    output logic             tc
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == Width'(Iterations - 1));

endmodule

// File: rtl/cordic_ctrl.sv
// Sequencer for the CORDIC datapath: load, iterate, then hold the
// result behind a valid/ready handshake.
module cordic_ctrl
    import cordic_pkg::*;
#(
    parameter  int Iterations = 16,
    localparam int IterWidth  = $clog2(Iterations)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic                 mode_i,
    output logic                 ready_o,
    output logic                 sel_o,
    output logic                 en_o,
    output logic [IterWidth-1:0] iter_o,
    output logic                 mode_o,
    output logic                 valid_o,
    input  logic                 ready_i
);

    state_e               state_q;
    state_e               state_d;
    mode_e                mode_q;
    logic                 cnt_en;
    logic                 cnt_clr;
    logic                 tc;
    logic [IterWidth-1:0] count;

    cordic_iter_cnt #(
        .Iterations(Iterations),
        .Width     (IterWidth)
    ) u_cnt (
        .clk  (clk_i),
        .rst_n(rst_ni),
        .en   (cnt_en),
        .clr  (cnt_clr),
        .count(count),
        .tc   (tc)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            mode_q  <= ROTATION;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && start_i) begin
                mode_q <= mode_e'(mode_i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_en  = 1'b0;
        cnt_clr = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i) state_d = LOAD;
            end
            LOAD: begin
                state_d = ITER;
                cnt_clr = 1'b1;
            end
            ITER: begin
                if (tc) begin
                    state_d = DONE;
                    cnt_clr = 1'b1;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            DONE: begin
                if (ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Every output is a decode of registered state only.
    always_comb begin
        ready_o = 1'b0;
        sel_o   = 1'b0;
        en_o    = 1'b0;
        valid_o = 1'b0;
        iter_o  = '0;
        unique case (state_q)
            IDLE: ready_o = 1'b1;
            LOAD: en_o = 1'b1;
            ITER: begin
                sel_o  = 1'b1;
                en_o   = 1'b1;
                iter_o = count;
            end
            DONE: begin
                sel_o   = 1'b1;
                valid_o = 1'b1;
            end
            default: ready_o = 1'b0;
        endcase
    end

    assign mode_o = mode_q;

endmodule
